// File: rtl/ex_wb_return_path_pkg.sv
// ----------------------------------------------------------------------------
// ex_wb_return_path_pkg
// Shared definitions for the EX -> MEM -> WB return path: default datapath
// widths, the hard-wired zero register number and the forwarding-select
// encoding used by the per-operand forwarding mux.
// ----------------------------------------------------------------------------
package ex_wb_return_path_pkg;

   // Default operand/result width and register-number width
   localparam int DATA_W = 32;
   localparam int REG_W  = 5;

   // Register 0 is hard-wired to zero: never written, never forwarded
   localparam logic [REG_W-1:0] REG_ZERO = '0;

   // Where a forwarded operand comes from
   typedef enum logic [1:0] {
      FWD_NONE,
      FWD_MEM,
      FWD_WB
   } fwd_sel_e;

endpackage

// File: rtl/ex_wb_return_path_if.sv
// ----------------------------------------------------------------------------
// ex_wb_return_path_if
// Bundles the EX-stage operands/result, the data-memory read data and the
// return-path outputs (forwarded operands, stall request, stage registers,
// register-file write port and bubble counter).
//   slave  : seen by ex_wb_return_path (EX inputs in, results out)
//   master : seen by the surrounding pipeline (drives EX, consumes results)
// ----------------------------------------------------------------------------
interface ex_wb_return_path_if #(
   parameter int DATA_W = ex_wb_return_path_pkg::DATA_W,
   parameter int REG_W  = ex_wb_return_path_pkg::REG_W,
   parameter int CNT_W  = 16
);

   logic [DATA_W-1:0] ex_rs_data;
   logic [DATA_W-1:0] ex_rt_data;
   logic [REG_W-1:0]  ex_rs_num;
   logic [REG_W-1:0]  ex_rt_num;
   logic [REG_W-1:0]  ex_rd;
   logic [DATA_W-1:0] ex_result;
   logic              ex_reg_write;
   logic              ex_is_load;
   logic              ex_flush;
   logic [DATA_W-1:0] mem_load_data;

   logic [DATA_W-1:0] fwd_rs;
   logic [DATA_W-1:0] fwd_rt;
   logic              stall_req;
   logic [DATA_W-1:0] mem_result;
   logic [DATA_W-1:0] wb_data;
   logic [REG_W-1:0]  wb_rd;
   logic              wb_en;
   logic [CNT_W-1:0]  bubble_count;

   modport slave (
      input  ex_rs_data, ex_rt_data, ex_rs_num, ex_rt_num, ex_rd,
             ex_result, ex_reg_write, ex_is_load, ex_flush, mem_load_data,
      output fwd_rs, fwd_rt, stall_req, mem_result, wb_data, wb_rd,
             wb_en, bubble_count
   );

   modport master (
      output ex_rs_data, ex_rt_data, ex_rs_num, ex_rt_num, ex_rd,
             ex_result, ex_reg_write, ex_is_load, ex_flush, mem_load_data,
      input  fwd_rs, fwd_rt, stall_req, mem_result, wb_data, wb_rd,
             wb_en, bubble_count
   );

endinterface

// File: rtl/ex_wb_return_path_fwd_select.sv
// ----------------------------------------------------------------------------
// fwd_select
// Combinational forwarding mux for one EX source operand.
//   num/ex_data          : source register number and the operand from ID/EX
//   mem_*                : EX/MEM stage contents
//   wb_*                 : MEM/WB stage contents
//   data                 : operand to use in EX
//   load_hit             : operand depends on the load currently in MEM
// ----------------------------------------------------------------------------
module fwd_select #(
   parameter int DATA_W = ex_wb_return_path_pkg::DATA_W,
   parameter int REG_W  = ex_wb_return_path_pkg::REG_W
) (
   input  logic [REG_W-1:0]  num,
   input  logic [DATA_W-1:0] ex_data,
   input  logic              mem_we,
   input  logic [REG_W-1:0]  mem_rd,
   input  logic              mem_is_load,
   input  logic [DATA_W-1:0] mem_result,
   input  logic              wb_en,
   input  logic [REG_W-1:0]  wb_rd,
   input  logic [DATA_W-1:0] wb_data,
   output logic [DATA_W-1:0] data,
   output logic              load_hit
);
   import ex_wb_return_path_pkg::*;

   fwd_sel_e sel;
   logic     num_nonzero;

   assign num_nonzero = (num != REG_W'(REG_ZERO));

   // A load sitting in MEM has only an address in mem_result, so it cannot
   // feed EX; the top turns this into a one-cycle stall instead.
   assign load_hit = mem_we && mem_is_load && num_nonzero && (mem_rd == num);

   // Pick the youngest in-flight producer. MEM is younger than WB, so it
   // wins when both target the same register. Register 0 always takes the
   // operand straight from ID/EX.
   always_comb begin
      sel = FWD_NONE;
      if (num_nonzero) begin
         if (mem_we && !mem_is_load && (mem_rd == num)) begin
            sel = FWD_MEM;
         end else if (wb_en && (wb_rd == num)) begin
            sel = FWD_WB;
         end
      end
   end

   // Steer the chosen source onto the operand.
   always_comb begin
      case (sel)
         FWD_MEM: data = mem_result;
         FWD_WB:  data = wb_data;
         default: data = ex_data;
      endcase
   end

endmodule

// File: rtl/ex_wb_return_path.sv
// ----------------------------------------------------------------------------
// ex_wb_return_path
// Carries EX results through the EX/MEM and MEM/WB registers to the
// register-file write port, forwards in-flight results back onto the EX
// operands, raises a one-cycle stall on load-use hazards and counts the
// stall bubbles it inserts.
//   clock : rising-edge pipeline clock
//   reset : asynchronous, active-high; clears every stage register
//   bus   : ex_wb_return_path_if.slave (EX inputs, load data, results)
// ----------------------------------------------------------------------------
module ex_wb_return_path #(
   parameter int DATA_W = ex_wb_return_path_pkg::DATA_W,
   parameter int REG_W  = ex_wb_return_path_pkg::REG_W,
   parameter int CNT_W  = 16
) (
   input  logic               clock,
   input  logic               reset,
   ex_wb_return_path_if.slave bus
);
   import ex_wb_return_path_pkg::*;

   logic [DATA_W-1:0] mem_result;
   logic [REG_W-1:0]  mem_rd;
   logic              mem_we;
   logic              mem_is_load;
   logic [DATA_W-1:0] wb_data;
   logic [REG_W-1:0]  wb_rd;
   logic              wb_en;
   logic [CNT_W-1:0]  bubble_count;

   logic              rs_load_hit;
   logic              rt_load_hit;
   logic              stall_req;
   logic              bubble;

   fwd_select #(.DATA_W(DATA_W), .REG_W(REG_W)) u_fwd_rs (
      .num         (bus.ex_rs_num),
      .ex_data     (bus.ex_rs_data),
      .mem_we      (mem_we),
      .mem_rd      (mem_rd),
      .mem_is_load (mem_is_load),
      .mem_result  (mem_result),
      .wb_en       (wb_en),
      .wb_rd       (wb_rd),
      .wb_data     (wb_data),
      .data        (bus.fwd_rs),
      .load_hit    (rs_load_hit)
   );

   fwd_select #(.DATA_W(DATA_W), .REG_W(REG_W)) u_fwd_rt (
      .num         (bus.ex_rt_num),
      .ex_data     (bus.ex_rt_data),
      .mem_we      (mem_we),
      .mem_rd      (mem_rd),
      .mem_is_load (mem_is_load),
      .mem_result  (mem_result),
      .wb_en       (wb_en),
      .wb_rd       (wb_rd),
      .wb_data     (wb_data),
      .data        (bus.fwd_rt),
      .load_hit    (rt_load_hit)
   );

   // A single bubble covers both a load-use stall and a branch flush; when
   // both happen together the flushed instruction is simply dropped.
   assign stall_req = rs_load_hit || rt_load_hit;
   assign bubble    = stall_req || bus.ex_flush;

   // EX/MEM register. A bubble loads an all-zero, non-writing slot so the
   // stalled or flushed instruction never reaches write-back from here.
   // Writes to register 0 are dropped at capture time.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         mem_result  <= '0;
         mem_rd      <= '0;
         mem_we      <= 1'b0;
         mem_is_load <= 1'b0;
      end else if (bubble) begin
         mem_result  <= '0;
         mem_rd      <= '0;
         mem_we      <= 1'b0;
         mem_is_load <= 1'b0;
      end else begin
         mem_result  <= bus.ex_result;
         mem_rd      <= bus.ex_rd;
         mem_we      <= bus.ex_reg_write && (bus.ex_rd != REG_W'(REG_ZERO));
         mem_is_load <= bus.ex_is_load;
      end
   end

   // MEM/WB register. Never stalled: this is what lets the load drain into
   // WB during the bubble so the waiting instruction can forward from WB on
   // the following cycle.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wb_data <= '0;
         wb_rd   <= '0;
         wb_en   <= 1'b0;
      end else begin
         wb_data <= mem_is_load ? bus.mem_load_data : mem_result;
         wb_rd   <= mem_rd;
         wb_en   <= mem_we;
      end
   end

   // Bubble counter: only load-use stalls count (a flush that coincides with
   // a stall still counts once). Sticks at all-ones instead of wrapping.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         bubble_count <= '0;
      end else if (stall_req && (bubble_count != {CNT_W{1'b1}})) begin
         bubble_count <= bubble_count + 1'b1;
      end
   end

   assign bus.stall_req    = stall_req;
   assign bus.mem_result   = mem_result;
   assign bus.wb_data      = wb_data;
   assign bus.wb_rd        = wb_rd;
   assign bus.wb_en        = wb_en;
   assign bus.bubble_count = bubble_count;

endmodule

// File: tb/tb_ex_wb_return_path.sv
// ----------------------------------------------------------------------------
// tb_ex_wb_return_path
// Directed bench for ex_wb_return_path. Two instances share one stimulus: a
// full-width bubble counter and a 3-bit one so that counter saturation can
// be reached in a few stalls. An instruction-level model tracks what is in
// flight in MEM and WB and predicts every output once per cycle; literal
// expectations at key points pin the model itself.
// ----------------------------------------------------------------------------
module tb_ex_wb_return_path;

   logic        clock = 1'b0;
   logic        reset = 1'b1;

   logic [31:0] ex_rs_data    = '0;
   logic [31:0] ex_rt_data    = '0;
   logic [4:0]  ex_rs_num     = '0;
   logic [4:0]  ex_rt_num     = '0;
   logic [4:0]  ex_rd         = '0;
   logic [31:0] ex_result     = '0;
   logic        ex_reg_write  = 1'b0;
   logic        ex_is_load    = 1'b0;
   logic        ex_flush      = 1'b0;
   logic [31:0] mem_load_data = '0;

   int checks = 0;
   int errors = 0;

   ex_wb_return_path_if #(.DATA_W(32), .REG_W(5), .CNT_W(16)) bus0 ();
   ex_wb_return_path_if #(.DATA_W(32), .REG_W(5), .CNT_W(3))  bus1 ();

   // Both instances see identical EX-side stimulus
   assign bus0.ex_rs_data    = ex_rs_data;
   assign bus0.ex_rt_data    = ex_rt_data;
   assign bus0.ex_rs_num     = ex_rs_num;
   assign bus0.ex_rt_num     = ex_rt_num;
   assign bus0.ex_rd         = ex_rd;
   assign bus0.ex_result     = ex_result;
   assign bus0.ex_reg_write  = ex_reg_write;
   assign bus0.ex_is_load    = ex_is_load;
   assign bus0.ex_flush      = ex_flush;
   assign bus0.mem_load_data = mem_load_data;
   assign bus1.ex_rs_data    = ex_rs_data;
   assign bus1.ex_rt_data    = ex_rt_data;
   assign bus1.ex_rs_num     = ex_rs_num;
   assign bus1.ex_rt_num     = ex_rt_num;
   assign bus1.ex_rd         = ex_rd;
   assign bus1.ex_result     = ex_result;
   assign bus1.ex_reg_write  = ex_reg_write;
   assign bus1.ex_is_load    = ex_is_load;
   assign bus1.ex_flush      = ex_flush;
   assign bus1.mem_load_data = mem_load_data;

   ex_wb_return_path #(.DATA_W(32), .REG_W(5), .CNT_W(16)) dut0 (
      .clock (clock),
      .reset (reset),
      .bus   (bus0.slave)
   );

   ex_wb_return_path #(.DATA_W(32), .REG_W(5), .CNT_W(3)) dut1 (
      .clock (clock),
      .reset (reset),
      .bus   (bus1.slave)
   );

   // 10-unit clock period
   always #5 clock = ~clock;

   // One in-flight instruction as the model sees it
   typedef struct {
      bit          writes;
      logic [4:0]  rd;
      logic [31:0] value;
      bit          isLoad;
   } inst_t;

   localparam inst_t EMPTY = '{writes: 1'b0, rd: 5'd0, value: 32'd0, isLoad: 1'b0};

   inst_t       inMem = EMPTY;
   inst_t       inWb  = EMPTY;
   int unsigned stallsSeen = 0;

   // Value EX should see: the newest finished producer of that register,
   // or the ID/EX operand when nothing in flight has it (or it is r0)
   function automatic logic [31:0] modelOperand(input logic [4:0] num, input logic [31:0] exData);
      if (num == 5'd0) return exData;
      if (inMem.writes && !inMem.isLoad && inMem.rd == num) return inMem.value;
      if (inWb.writes && inWb.rd == num) return inWb.value;
      return exData;
   endfunction

   // EX must wait when it reads a register a load in MEM has not yet fetched
   function automatic bit modelStall();
      bit rsDep, rtDep;
      rsDep = (ex_rs_num != 5'd0) && (ex_rs_num == inMem.rd);
      rtDep = (ex_rt_num != 5'd0) && (ex_rt_num == inMem.rd);
      return inMem.writes && inMem.isLoad && (rsDep || rtDep);
   endfunction

   function automatic int unsigned satCount(input int unsigned n, input int unsigned maxv);
      return (n > maxv) ? maxv : n;
   endfunction

   // Advance the model one instruction step per clock edge
   always @(posedge clock or posedge reset) begin
      bit stallNow;
      if (reset) begin
         inMem      = EMPTY;
         inWb       = EMPTY;
         stallsSeen = 0;
      end else begin
         stallNow = modelStall();
         if (stallNow) stallsSeen++;
         inWb = inMem;
         if (inMem.isLoad) inWb.value = mem_load_data;
         inWb.isLoad = 1'b0;
         if (stallNow || ex_flush) begin
            inMem = EMPTY;
         end else begin
            inMem.writes = ex_reg_write && (ex_rd != 5'd0);
            inMem.rd     = ex_rd;
            inMem.value  = ex_result;
            inMem.isLoad = ex_is_load;
         end
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s at %0t: got 0x%08h, want 0x%08h", name, $time, actual, expected);
      end
   endtask

   // Cycle-by-cycle comparison against the model, mid-way through the low phase
   always @(negedge clock) begin
      #2;
      if (!reset) begin
         checkOutput("fwd_rs",       bus0.fwd_rs,       modelOperand(ex_rs_num, ex_rs_data));
         checkOutput("fwd_rt",       bus0.fwd_rt,       modelOperand(ex_rt_num, ex_rt_data));
         checkOutput("stall_req",    32'(bus0.stall_req), 32'(modelStall()));
         checkOutput("mem_result",   bus0.mem_result,   inMem.value);
         checkOutput("wb_data",      bus0.wb_data,      inWb.value);
         checkOutput("wb_rd",        32'(bus0.wb_rd),   32'(inWb.rd));
         checkOutput("wb_en",        32'(bus0.wb_en),   32'(inWb.writes));
         checkOutput("bubble_count", 32'(bus0.bubble_count), satCount(stallsSeen, 32'hFFFF));
         checkOutput("bubble_count_3b", 32'(bus1.bubble_count), satCount(stallsSeen, 7));
      end
   end

   // Present one EX instruction at the falling edge, return 3 units later
   task automatic applyStimulus(
      input logic [4:0]  rsNum, input logic [31:0] rsData,
      input logic [4:0]  rtNum, input logic [31:0] rtData,
      input logic [4:0]  rd,    input logic [31:0] result,
      input logic        regWrite, input logic isLoad, input logic flush,
      input logic [31:0] loadData
   );
      @(negedge clock);
      ex_rs_num     = rsNum;
      ex_rs_data    = rsData;
      ex_rt_num     = rtNum;
      ex_rt_data    = rtData;
      ex_rd         = rd;
      ex_result     = result;
      ex_reg_write  = regWrite;
      ex_is_load    = isLoad;
      ex_flush      = flush;
      mem_load_data = loadData;
      #3;
   endtask

   task automatic nop();
      applyStimulus(5'd0, 32'd0, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0);
   endtask

   initial begin
      // Reset state
      repeat (2) @(negedge clock);
      #1;
      checkOutput("reset_wb_en",        32'(bus0.wb_en), 32'd0);
      checkOutput("reset_wb_data",      bus0.wb_data, 32'd0);
      checkOutput("reset_mem_result",   bus0.mem_result, 32'd0);
      checkOutput("reset_bubble_count", 32'(bus0.bubble_count), 32'd0);
      @(negedge clock);
      reset = 1'b0;

      // Back-to-back ALU dependence: r3 = 0x10, forwarded from MEM then WB
      applyStimulus(5'd0, 32'd0, 5'd0, 32'd0, 5'd3, 32'h10, 1'b1, 1'b0, 1'b0, 32'd0);
      applyStimulus(5'd3, 32'hDEAD, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0);
      checkOutput("b2b_fwd_mem", bus0.fwd_rs, 32'h10);
      applyStimulus(5'd3, 32'hDEAD, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0);
      checkOutput("b2b_fwd_wb", bus0.fwd_rs, 32'h10);
      checkOutput("b2b_wb_rd",  32'(bus0.wb_rd), 32'd3);
      checkOutput("b2b_wb_en",  32'(bus0.wb_en), 32'd1);

      // Load-use on RT: load r5, then consumer stalls once
      applyStimulus(5'd0, 32'd0, 5'd0, 32'd0, 5'd5, 32'h100, 1'b1, 1'b1, 1'b0, 32'd0);
      applyStimulus(5'd0, 32'd0, 5'd5, 32'h1111, 5'd6, 32'h77, 1'b1, 1'b0, 1'b0, 32'hCAFEF00D);
      checkOutput("lu_stall",       32'(bus0.stall_req), 32'd1);
      checkOutput("lu_fwd_rt_wait", bus0.fwd_rt, 32'h1111);
      applyStimulus(5'd0, 32'd0, 5'd5, 32'h1111, 5'd6, 32'h77, 1'b1, 1'b0, 1'b0, 32'd0);
      checkOutput("lu_stall_drop",  32'(bus0.stall_req), 32'd0);
      checkOutput("lu_fwd_rt",      bus0.fwd_rt, 32'hCAFEF00D);
      checkOutput("lu_count",       32'(bus0.bubble_count), 32'd1);

      // MEM over WB: r4=1 then r4=2, reader sees 2
      applyStimulus(5'd0, 32'd0, 5'd0, 32'd0, 5'd4, 32'h1, 1'b1, 1'b0, 1'b0, 32'd0);
      applyStimulus(5'd0, 32'd0, 5'd0, 32'd0, 5'd4, 32'h2, 1'b1, 1'b0, 1'b0, 32'd0);
      applyStimulus(5'd4, 32'd0, 5'd4, 32'hFFFF, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0);
      checkOutput("prio_fwd_rs",  bus0.fwd_rs, 32'h2);
      checkOutput("prio_fwd_rt",  bus0.fwd_rt, 32'h2);
      checkOutput("prio_wb_data", bus0.wb_data, 32'h1);

      // Register 0: write is dropped, read passes ID/EX operand through
      applyStimulus(5'd0, 32'd0, 5'd0, 32'd0, 5'd0, 32'h55, 1'b1, 1'b0, 1'b0, 32'd0);
      applyStimulus(5'd0, 32'hABC, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0);
      checkOutput("r0_fwd_rs",     bus0.fwd_rs, 32'hABC);
      checkOutput("r0_mem_result", bus0.mem_result, 32'h55);
      nop();
      checkOutput("r0_wb_en",      32'(bus0.wb_en), 32'd0);

      // Flush during load-use: one bubble, counted once, flushed slot never writes
      applyStimulus(5'd0, 32'd0, 5'd0, 32'd0, 5'd7, 32'h200, 1'b1, 1'b1, 1'b0, 32'd0);
      applyStimulus(5'd7, 32'd0, 5'd0, 32'd0, 5'd8, 32'h99, 1'b1, 1'b0, 1'b1, 32'h1234);
      checkOutput("fl_stall", 32'(bus0.stall_req), 32'd1);
      nop();
      checkOutput("fl_count",   32'(bus0.bubble_count), 32'd2);
      checkOutput("fl_load_wb", bus0.wb_data, 32'h1234);
      nop();
      checkOutput("fl_wb_en",   32'(bus0.wb_en), 32'd0);

      // Ten more load-use pairs: full counter reaches 12, 3-bit counter sticks at 7
      for (int i = 0; i < 10; i++) begin
         applyStimulus(5'd0, 32'd0, 5'd0, 32'd0, 5'd9, 32'(i), 1'b1, 1'b1, 1'b0, 32'd0);
         applyStimulus(5'd9, 32'd0, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0, 32'(i + 100));
      end
      nop();
      checkOutput("sat_count_16", 32'(bus0.bubble_count), 32'd12);
      checkOutput("sat_count_3",  32'(bus1.bubble_count), 32'd7);

      // Reset between edges with live MEM/WB contents
      applyStimulus(5'd0, 32'd0, 5'd0, 32'd0, 5'd10, 32'h5A, 1'b1, 1'b0, 1'b0, 32'd0);
      applyStimulus(5'd0, 32'd0, 5'd0, 32'd0, 5'd11, 32'h6B, 1'b1, 1'b0, 1'b0, 32'd0);
      nop();
      checkOutput("pre_rst_wb_en",   32'(bus0.wb_en), 32'd1);
      checkOutput("pre_rst_wb_data", bus0.wb_data, 32'h5A);
      reset = 1'b1;
      #1;
      checkOutput("rst_wb_en",        32'(bus0.wb_en), 32'd0);
      checkOutput("rst_wb_data",      bus0.wb_data, 32'd0);
      checkOutput("rst_mem_result",   bus0.mem_result, 32'd0);
      checkOutput("rst_bubble_count", 32'(bus0.bubble_count), 32'd0);
      checkOutput("rst_bubble_3b",    32'(bus1.bubble_count), 32'd0);
      @(negedge clock);
      reset = 1'b0;
      nop();
      nop();
      checkOutput("post_rst_wb_en", 32'(bus0.wb_en), 32'd0);

      @(negedge clock);
      #4;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
